// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Requester IDs double as the addr_sel encoding.
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  localparam int MAX_MEM_LAT = 7;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational round-robin picker for two requesters (bit 0 = IF, bit 1 = DM).
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_id,
  output logic       any
);

  always_comb begin
    // NOTE: every always_comb output gets a default first; a missing branch would otherwise infer a latch.
    grant_id = REQ_IF;
    any      = |req;
    if (req == 2'b11) begin
      grant_id = ~last;
    end else if (req[REQ_DM]) begin
      grant_id = REQ_DM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data
// load/store, one access at a time, with round-robin arbitration.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          addr_sel,
  output logic          busy
);

  localparam int CW = $clog2(MAX_MEM_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(MEM_LAT);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic          pick_id;
  logic          pick_any;

  rr_pick2 u_pick (
    .req      ({dm_req, if_req}),
    .last     (last_grant),
    .grant_id (pick_id),
    .any      (pick_any)
  );

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= REQ_IF;
      addr_sel   <= REQ_IF;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      mem_en <= 1'b0;
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            addr_sel   <= pick_id;
            last_grant <= pick_id;
            mem_en     <= 1'b1;
            if (pick_id == REQ_DM) begin
              mem_addr  <= dm_addr;
              mem_we    <= dm_we;
              mem_wdata <= dm_wdata;
            end else begin
              mem_addr  <= if_addr;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= CW'(1);
          state <= WAIT;
        end
        WAIT: begin
          // The granted side is remembered in addr_sel, so a dropped req cannot cancel the access.
          if (cnt == LAT) begin
            if (addr_sel == REQ_DM) begin
              dm_ack <= 1'b1;
              if (!mem_we) dm_rdata <= mem_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the MIPS32 core between two requesters: instruction fetch (IF) and data load/store (DM).
- Arbitrates between them, sequences one fixed-latency access at a time, and returns read data and a one-cycle acknowledge to the requester it served.
- Drives addr_sel, the select of the 32-bit 2:1 address/data mux in front of the memory port (0 = fetch, 1 = data).

Parameters:
- DW, 32, data width.
- AW, 32, address width.
- MEM_LAT, 2, memory read latency in cycles from the issue cycle to valid mem_rdata; legal range 1..7.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; level, held until if_ack.
- if_addr  in  AW  fetch address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse: fetch complete.
- if_rdata  out  DW  fetched word; valid when if_ack is high, held afterwards.
- dm_req  in  1  data request; level, held until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- dm_ack  out  1  one-cycle pulse: data access complete.
- dm_rdata  out  DW  load data; valid when dm_ack is high, held afterwards.
- mem_en  out  1  memory access strobe; high for exactly one cycle per access.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  AW  registered access address.
- mem_wdata  out  DW  registered store data.
- mem_rdata  in  DW  memory read data; valid MEM_LAT cycles after the mem_en cycle.
- addr_sel  out  1  mux select for the granted requester (0 = IF, 1 = DM).
- busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE.
- Reset values: state IDLE; all outputs 0, including if_rdata and dm_rdata; last_grant = IF, so DM wins the first contention.
- Reset asserted mid-access: everything returns to reset values immediately, the in-flight access is abandoned, and no ack is issued.
- IDLE, when at least one request is high:
  - Pick the winner: if only one requester is asking, it wins; if both are asking, the one that is not last_grant wins (round-robin).
  - At the clock edge, register the winner's addr, we (forced 0 for IF) and wdata into mem_addr, mem_we and mem_wdata.
  - Register addr_sel, update last_grant, and go to ISSUE.
- ISSUE: mem_en = 1 for this cycle only. Load the counter with 1 and go to WAIT.
- WAIT: mem_en = 0. The counter increments each cycle.
  - In the cycle where the counter equals MEM_LAT, mem_rdata is valid.
  - At that edge, for a read, capture mem_rdata into the granted requester's rdata register, pulse the granted ack, and go to DONE.
  - A store completes on the same schedule; dm_rdata is left unchanged.
- DONE: the ack is high this cycle. Requests are ignored this cycle so the requester can drop or update req. Return to IDLE.
- Latency: a request first seen in IDLE at cycle T is acked in cycle T+2+MEM_LAT. The earliest next grant is in cycle T+3+MEM_LAT.
- addr_sel, mem_addr, mem_we and mem_wdata hold their values from grant until the next grant.
- A requester dropping req before its ack is a protocol violation; the access still completes and is acked.
- if_ack and dm_ack are never high in the same cycle.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE = 0, ISSUE = 1, WAIT = 2, DONE = 3);
  - the requester IDs (REQ_IF = 0, REQ_DM = 1), which are also the addr_sel encoding;
  - the maximum MEM_LAT constant (7).
- One natural sub-module: rr_pick2. It is the combinational 2-requester round-robin picker with inputs req[1:0] and last, and outputs grant_id and any. The counter and FSM stay in the top module.

Test Plan (MEM_LAT = 2):
- Reset, then IF read only (if_addr = 0x00400000, mem_rdata = 0x8C080004 in the valid cycle):
  - mem_en is high once, with mem_addr = 0x00400000 and addr_sel = 0;
  - if_ack pulses 4 cycles after req is first seen, with if_rdata = 0x8C080004.
- Both requests high in the same cycle after reset:
  - DM is served first (addr_sel = 1), then IF;
  - acks arrive 5 cycles apart, with no overlap.
- DM store (dm_addr = 0x10010000, dm_wdata = 0xDEADBEEF):
  - one cycle of mem_en = mem_we = 1 with those values;
  - dm_ack arrives after 4 cycles;
  - dm_rdata is unchanged.
- Both requests held continuously for 6 accesses: grants alternate DM, IF, DM, IF, DM, IF.
- rst asserted during WAIT:
  - all outputs are 0 in the same cycle, and no ack follows;
  - after release, a pending IF request is served normally.
- MEM_LAT = 1 and MEM_LAT = 7 builds: ack appears exactly MEM_LAT+2 cycles after the request is first seen.
